// File: rtl/hif_tx_pkt_arbiter.sv
// hif_tx_pkt_arbiter: packet-level round-robin merge of host Tx AXI-Stream
// sources 0 and 1 onto a single MAC Tx stream in the i_hif_clk domain.
// Packets are never interleaved; the output stage is a single register slice.
// Optional per-source packet counters are built when HIF_TX_ARB_PKT_CNT_EN
// is defined.
module hif_tx_pkt_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned USER_W = 1
`ifdef HIF_TX_ARB_PKT_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              i_hif_clk,
    input  logic              i_hif_rst,
    input  logic [1:0]        i_port_en,

    input  logic              i_s0_axis_tvalid,
    input  logic              i_s0_axis_tlast,
    input  logic [DATA_W-1:0] i_s0_axis_tdata,
    input  logic [KEEP_W-1:0] i_s0_axis_tkeep,
    input  logic [USER_W-1:0] i_s0_axis_tuser,
    output logic              o_s0_axis_tready,

    input  logic              i_s1_axis_tvalid,
    input  logic              i_s1_axis_tlast,
    input  logic [DATA_W-1:0] i_s1_axis_tdata,
    input  logic [KEEP_W-1:0] i_s1_axis_tkeep,
    input  logic [USER_W-1:0] i_s1_axis_tuser,
    output logic              o_s1_axis_tready,

    output logic              o_m_axis_tvalid,
    output logic              o_m_axis_tlast,
    output logic [DATA_W-1:0] o_m_axis_tdata,
    output logic [KEEP_W-1:0] o_m_axis_tkeep,
    output logic [USER_W-1:0] o_m_axis_tuser,
    input  logic              i_m_axis_tready,

    output logic [1:0]        o_grant,
    output logic              o_busy
`ifdef HIF_TX_ARB_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_pkt_cnt_0,
    output logic [CNT_W-1:0]  o_pkt_cnt_1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_port;  // source that finished the most recent packet
    logic   in_pkt;     // at least one beat of the current packet accepted

    logic req0;
    logic req1;
    logic out_free;
    logic acc0;
    logic acc1;

    // Eligibility, output-slice availability and per-source handshakes
    assign req0     = i_s0_axis_tvalid && i_port_en[0];
    assign req1     = i_s1_axis_tvalid && i_port_en[1];
    assign out_free = !o_m_axis_tvalid || i_m_axis_tready;

    assign o_s0_axis_tready = (state == ST_GRANT0) && out_free;
    assign o_s1_axis_tready = (state == ST_GRANT1) && out_free;

    assign acc0 = i_s0_axis_tvalid && o_s0_axis_tready;
    assign acc1 = i_s1_axis_tvalid && o_s1_axis_tready;

    assign o_grant = {state == ST_GRANT1, state == ST_GRANT0};
    assign o_busy  = (state != ST_IDLE) || o_m_axis_tvalid;

    // Arbitration FSM: grants change only in IDLE or on an accepted tlast.
    // A grant carried over a packet boundary is released if the source has
    // nothing to send, so an idle source cannot hold the MAC.
    always_ff @(posedge i_hif_clk) begin
        if (i_hif_rst) begin
            state     <= ST_IDLE;
            last_port <= 1'b1;
            in_pkt    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 && (last_port || !req1)) begin
                        state <= ST_GRANT0;
                    end else if (req1) begin
                        state <= ST_GRANT1;
                    end
                end
                ST_GRANT0: begin
                    if (acc0) begin
                        if (i_s0_axis_tlast) begin
                            last_port <= 1'b0;
                            in_pkt    <= 1'b0;
                            if (req1) begin
                                state <= ST_GRANT1;
                            end else if (req0) begin
                                state <= ST_GRANT0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            in_pkt <= 1'b1;
                        end
                    end else if (!in_pkt && !i_s0_axis_tvalid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT1: begin
                    if (acc1) begin
                        if (i_s1_axis_tlast) begin
                            last_port <= 1'b1;
                            in_pkt    <= 1'b0;
                            if (req0) begin
                                state <= ST_GRANT0;
                            end else if (req1) begin
                                state <= ST_GRANT1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            in_pkt <= 1'b1;
                        end
                    end else if (!in_pkt && !i_s1_axis_tvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register slice: load on accept, drop valid once the MAC takes it
    always_ff @(posedge i_hif_clk) begin
        if (i_hif_rst) begin
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tlast  <= 1'b0;
            o_m_axis_tdata  <= '0;
            o_m_axis_tkeep  <= '0;
            o_m_axis_tuser  <= '0;
        end else if (acc0) begin
            o_m_axis_tvalid <= 1'b1;
            o_m_axis_tlast  <= i_s0_axis_tlast;
            o_m_axis_tdata  <= i_s0_axis_tdata;
            o_m_axis_tkeep  <= i_s0_axis_tkeep;
            o_m_axis_tuser  <= i_s0_axis_tuser;
        end else if (acc1) begin
            o_m_axis_tvalid <= 1'b1;
            o_m_axis_tlast  <= i_s1_axis_tlast;
            o_m_axis_tdata  <= i_s1_axis_tdata;
            o_m_axis_tkeep  <= i_s1_axis_tkeep;
            o_m_axis_tuser  <= i_s1_axis_tuser;
        end else if (i_m_axis_tready) begin
            o_m_axis_tvalid <= 1'b0;
        end
    end

`ifdef HIF_TX_ARB_PKT_CNT_EN
    // Per-source packet counters, wrapping, counted on accepted tlast beats
    always_ff @(posedge i_hif_clk) begin
        if (i_hif_rst) begin
            o_pkt_cnt_0 <= '0;
            o_pkt_cnt_1 <= '0;
        end else begin
            if (acc0 && i_s0_axis_tlast) begin
                o_pkt_cnt_0 <= o_pkt_cnt_0 + CNT_W'(1);
            end
            if (acc1 && i_s1_axis_tlast) begin
                o_pkt_cnt_1 <= o_pkt_cnt_1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hif_tx_pkt_arbiter.sv
// tb_hif_tx_pkt_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based scoreboard of the packets each source handed over.
// Source 1 data always carries bit 63 set so every output beat names its source.
module tb_hif_tx_pkt_arbiter;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned USER_W = 1;
    localparam logic [63:0] TAG    = 64'h8000_0000_0000_0000;
`ifdef HIF_TX_ARB_PKT_CNT_EN
    localparam int unsigned CNT_W  = 3;
    logic [CNT_W-1:0] pkt_cnt_0;
    logic [CNT_W-1:0] pkt_cnt_1;
`endif

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        user;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        en  = 2'b11;
    logic              s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
    logic [DATA_W-1:0] s0_tdata = '0;
    logic [KEEP_W-1:0] s0_tkeep = '0;
    logic [USER_W-1:0] s0_tuser = '0;
    logic              s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
    logic [DATA_W-1:0] s1_tdata = '0;
    logic [KEEP_W-1:0] s1_tkeep = '0;
    logic [USER_W-1:0] s1_tuser = '0;
    logic              m_tvalid, m_tlast;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic [USER_W-1:0] m_tuser;
    logic              m_tready = 1'b0;
    logic [1:0]        grant;
    logic              busy;

    always #5 clk = ~clk;

    hif_tx_pkt_arbiter #(
        .DATA_W(DATA_W),
        .KEEP_W(KEEP_W),
        .USER_W(USER_W)
`ifdef HIF_TX_ARB_PKT_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .i_hif_clk        (clk),
        .i_hif_rst        (rst),
        .i_port_en        (en),
        .i_s0_axis_tvalid (s0_tvalid),
        .i_s0_axis_tlast  (s0_tlast),
        .i_s0_axis_tdata  (s0_tdata),
        .i_s0_axis_tkeep  (s0_tkeep),
        .i_s0_axis_tuser  (s0_tuser),
        .o_s0_axis_tready (s0_tready),
        .i_s1_axis_tvalid (s1_tvalid),
        .i_s1_axis_tlast  (s1_tlast),
        .i_s1_axis_tdata  (s1_tdata),
        .i_s1_axis_tkeep  (s1_tkeep),
        .i_s1_axis_tuser  (s1_tuser),
        .o_s1_axis_tready (s1_tready),
        .o_m_axis_tvalid  (m_tvalid),
        .o_m_axis_tlast   (m_tlast),
        .o_m_axis_tdata   (m_tdata),
        .o_m_axis_tkeep   (m_tkeep),
        .o_m_axis_tuser   (m_tuser),
        .i_m_axis_tready  (m_tready),
        .o_grant          (grant),
        .o_busy           (busy)
`ifdef HIF_TX_ARB_PKT_CNT_EN
        ,
        .o_pkt_cnt_0      (pkt_cnt_0),
        .o_pkt_cnt_1      (pkt_cnt_1)
`endif
    );

    // Scoreboard state: packets still to send, beats accepted but not yet seen
    beat_t       sq0[$], sq1[$], eq0[$], eq1[$];
    logic [63:0] log_data[$];
    int          log_cyc[$];
    logic        log_last[$];
    logic [1:0]  g_log[$];
    logic        pres0, pres1;
    logic        out_in_pkt, out_src;
    logic        stall_prev;
    logic [63:0] hold_data;
    logic [9:0]  hold_side;
    int          vprob0, vprob1, rprob;
    logic        rdy_toggle;
    int          cyc;
    int          stalls;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic clear_model();
        sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
        log_data.delete(); log_cyc.delete(); log_last.delete(); g_log.delete();
        pres0 = 1'b0; pres1 = 1'b0;
        out_in_pkt = 1'b0; out_src = 1'b0;
        stall_prev = 1'b0; stalls = 0; cyc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; en = 2'b11;
        vprob0 = 100; vprob1 = 100; rprob = 100; rdy_toggle = 1'b0;
        clear_model();
    endtask

    task automatic add_pkt(input int port, input int len, input logic [63:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = (base + 64'(i)) | (port == 1 ? TAG : 64'd0);
            b.keep = 8'hFF; b.user = 1'b0; b.last = (i == len - 1);
            if (port == 0) sq0.push_back(b); else sq1.push_back(b);
        end
    endtask

    task automatic add_rand_pkt(input int port);
        beat_t b;
        int len;
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
            b.data = {32'($urandom), 32'($urandom)};
            b.data = (port == 1) ? (b.data | TAG) : (b.data & ~TAG);
            b.keep = 8'($urandom); b.user = 1'($urandom); b.last = (i == len - 1);
            if (port == 0) sq0.push_back(b); else sq1.push_back(b);
        end
    endtask

    // Observe one cycle just before the active edge and update the scoreboard
    task automatic sample_cycle();
        beat_t e;
        g_log.push_back(grant);
        check("busy", 64'(busy), 64'((grant != 2'b00) || m_tvalid));
        if (grant == 2'b01) check("s0_tready", 64'(s0_tready), 64'(!m_tvalid || m_tready));
        else                check("s0_tready_gated", 64'(s0_tready), 64'(0));
        if (grant == 2'b10) check("s1_tready", 64'(s1_tready), 64'(!m_tvalid || m_tready));
        else                check("s1_tready_gated", 64'(s1_tready), 64'(0));
        if (stall_prev) begin
            check("hold_valid", 64'(m_tvalid), 64'(1));
            check("hold_data", m_tdata, hold_data);
            check("hold_side", 64'({m_tkeep, m_tuser, m_tlast}), 64'(hold_side));
        end
        stall_prev = m_tvalid && !m_tready;
        if (stall_prev) stalls++;
        hold_data = m_tdata;
        hold_side = {m_tkeep, m_tuser, m_tlast};
        if (m_tvalid && m_tready) begin
            if (out_in_pkt) check("no_interleave", 64'(m_tdata[63]), 64'(out_src));
            out_src = m_tdata[63];
            out_in_pkt = !m_tlast;
            check("beat_expected", 64'((out_src ? eq1.size() : eq0.size()) > 0), 64'(1));
            if ((out_src ? eq1.size() : eq0.size()) > 0) begin
                e = out_src ? eq1.pop_front() : eq0.pop_front();
                check("beat_data", m_tdata, e.data);
                check("beat_side", 64'({m_tkeep, m_tuser, m_tlast}), 64'({e.keep, e.user, e.last}));
            end
            log_data.push_back(m_tdata);
            log_cyc.push_back(cyc);
            log_last.push_back(m_tlast);
        end
        if (pres0 && s0_tready) begin eq0.push_back(sq0.pop_front()); pres0 = 1'b0; end
        if (pres1 && s1_tready) begin eq1.push_back(sq1.pop_front()); pres1 = 1'b0; end
    endtask

    // One clock: drive sources and MAC ready, sample, advance past the edge
    task automatic step();
        beat_t b;
        if (!pres0 && sq0.size() > 0 && int'($urandom_range(0, 99)) < vprob0) pres0 = 1'b1;
        if (!pres1 && sq1.size() > 0 && int'($urandom_range(0, 99)) < vprob1) pres1 = 1'b1;
        s0_tvalid = pres0; s1_tvalid = pres1;
        b = pres0 ? sq0[0] : '0;
        s0_tdata = b.data; s0_tkeep = b.keep; s0_tuser = b.user; s0_tlast = b.last;
        b = pres1 ? sq1[0] : '0;
        s1_tdata = b.data; s1_tkeep = b.keep; s1_tuser = b.user; s1_tlast = b.last;
        m_tready = rdy_toggle ? ((cyc % 2) == 0) : (int'($urandom_range(0, 99)) < rprob);
        #3;
        sample_cycle();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_outputs(input string tag, input int n_out, input int budget);
        int n = 0;
        while (log_data.size() < n_out && n < budget) begin step(); n++; end
        check(tag, 64'(log_data.size()), 64'(n_out));
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((sq0.size() + sq1.size() + eq0.size() + eq1.size()) != 0 && n < budget) begin
            step(); n++;
        end
        check(tag, 64'(sq0.size() + sq1.size() + eq0.size() + eq1.size()), 64'(0));
    endtask

    initial begin
        logic [7:0] cont_seq [12];

        // Reset values
        do_reset();
        check("rst_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_tlast", 64'(m_tlast), 64'(0));
        check("rst_tdata", m_tdata, 64'(0));
        check("rst_side", 64'({m_tkeep, m_tuser}), 64'(0));
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_treadys", 64'({s0_tready, s1_tready}), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // Single source, 4 beats, MAC always ready
        add_pkt(0, 4, 64'd1);
        for (int k = 0; k < 8; k++) step();
        check("single_count", 64'(log_data.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("single_data", log_data[i], 64'(i + 1));
            check("single_cycle", 64'(log_cyc[i]), 64'(2 + i));
        end
        check("single_tlast_mid", 64'(log_last[2]), 64'(0));
        check("single_tlast_end", 64'(log_last[3]), 64'(1));
        check("single_grant_idle", 64'(g_log[0]), 64'(2'b00));
        check("single_grant_first", 64'(g_log[1]), 64'(2'b01));
        check("single_grant_mid", 64'(g_log[4]), 64'(2'b01));
        check("single_grant_after", 64'(g_log[7]), 64'(2'b00));

        // Contention: alternating whole packets, no bubbles after the first
        do_reset();
        cont_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3,
                     8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
        add_pkt(0, 3, 64'hA1); add_pkt(0, 3, 64'hA1);
        add_pkt(1, 3, 64'hB1); add_pkt(1, 3, 64'hB1);
        run_outputs("cont_count", 12, 40);
        for (int i = 0; i < 12; i++) begin
            check("cont_order", 64'(log_data[i][7:0]), 64'(cont_seq[i]));
            check("cont_cycle", 64'(log_cyc[i]), 64'(2 + i));
        end

        // Backpressure on a 5-beat source 1 packet
        do_reset();
        rdy_toggle = 1'b1;
        add_pkt(1, 5, 64'd1);
        run_outputs("bp_count", 5, 60);
        for (int i = 0; i < 5; i++) check("bp_data", log_data[i], TAG | 64'(i + 1));
        check("bp_stalls_seen", 64'(stalls > 0), 64'(1));

        // Enable cleared mid-packet on port 0 while port 1 waits
        do_reset();
        add_pkt(0, 4, 64'h01); add_pkt(0, 2, 64'h11);
        add_pkt(1, 2, 64'h21);
        for (int k = 0; k < 30; k++) begin
            if (cyc == 2) en = 2'b10;
            step();
        end
        check("en_count", 64'(log_data.size()), 64'(6));
        check("en_b0", 64'(log_data[0][7:0]), 64'h01);
        check("en_b3", 64'(log_data[3][7:0]), 64'h04);
        check("en_b3_last", 64'(log_last[3]), 64'(1));
        check("en_b4", log_data[4], TAG | 64'h21);
        check("en_b5", log_data[5], TAG | 64'h22);
        check("en_blocked", 64'(sq0.size()), 64'(2));
        check("en_grant_end", 64'(g_log[29]), 64'(2'b00));

        // Reset during beat 3 of 6, then both sources request
        do_reset();
        add_pkt(0, 6, 64'd1);
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_tvalid", 64'(m_tvalid), 64'(0));
        check("midrst_grant", 64'(grant), 64'(2'b00));
        check("midrst_busy", 64'(busy), 64'(0));
        clear_model();
        add_pkt(0, 2, 64'h31); add_pkt(1, 2, 64'h41);
        run_outputs("midrst_count", 4, 40);
        check("midrst_first_grant", 64'(g_log[1]), 64'(2'b01));
        check("midrst_first_beat", log_data[0], 64'h31);
        check("midrst_second_pkt", log_data[2], TAG | 64'h41);

        // Randomized traffic with random source valid gaps and MAC ready
        do_reset();
        vprob0 = 60; vprob1 = 60; rprob = 70;
        for (int p = 0; p < 15; p++) begin add_rand_pkt(0); add_rand_pkt(1); end
        drain("rand_drain", 4000);

`ifdef HIF_TX_ARB_PKT_CNT_EN
        // Packet counters: wrap on source 0, simple count on source 1
        do_reset();
        for (int p = 0; p < 7; p++) add_pkt(0, 1, 64'(p));
        drain("cnt_fill", 200);
        check("cnt0_full", 64'(pkt_cnt_0), 64'(7));
        add_pkt(0, 2, 64'h50);
        drain("cnt_wrap_drain", 200);
        check("cnt0_wrap", 64'(pkt_cnt_0), 64'(0));
        for (int p = 0; p < 3; p++) add_pkt(1, 2, 64'h60);
        drain("cnt1_drain", 200);
        check("cnt1_three", 64'(pkt_cnt_1), 64'(3));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
